// File: rtl/core_run_ctrl_if.sv
// Program-load stream plus instruction-memory write port of the run controller.
// master = program source / memory side, slave = core_run_ctrl.
interface core_run_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Load/run sequencer: streams a program into imem (zero-latency write, ready only in LOAD), then runs
// the core until HALT_INSN or the cycle budget; CORE_RUN_CTRL_SINGLE_STEP_EN adds step_mode/step gating.
module core_run_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 6,
  parameter int                CYCLE_W   = 16,
  parameter logic [DATA_W-1:0] HALT_INSN = 32'hFC00_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CYCLE_W-1:0] cycle_budget,
  core_run_ctrl_if.slave     bus,
  output logic               core_rst_n,
  output logic               core_ce,
  input  logic [DATA_W-1:0]  core_instr,
`ifdef CORE_RUN_CTRL_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               busy,
  output logic               done,
  output logic               halted,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycles
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0]  PTR_MAX = '1;
  localparam logic [CYCLE_W-1:0] CYC_MAX = '1;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [CYCLE_W-1:0] budget_q;
  logic [CYCLE_W-1:0] cyc_inc;
  logic               wr;
  logic               adv;

`ifdef CORE_RUN_CTRL_SINGLE_STEP_EN
  assign adv = (state == S_RUN) && (!step_mode || step);
`else
  assign adv = (state == S_RUN);
`endif

  assign wr             = (state == S_LOAD) && bus.load_valid;
  assign bus.load_ready = (state == S_LOAD);
  assign bus.imem_we    = wr;
  assign bus.imem_waddr = ptr;
  assign bus.imem_wdata = bus.load_data;

  assign core_rst_n = (state == S_RUN);
  assign core_ce    = adv;
  assign busy       = (state == S_LOAD) || (state == S_RUN);
  assign done       = (state == S_DONE);

  // Saturating count: only reachable with an unlimited (zero) budget.
  assign cyc_inc = (cycles == CYC_MAX) ? cycles : cycles + CYCLE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      budget_q <= '0;
      cycles   <= '0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            ptr      <= '0;
            cycles   <= '0;
            halted   <= 1'b0;
            timeout  <= 1'b0;
            budget_q <= cycle_budget;
          end
        end
        S_LOAD: begin
          if (wr) begin
            if (bus.load_last || ptr == PTR_MAX) state <= S_RUN;
            // Pointer parks at the top address so a full memory never wraps.
            if (ptr != PTR_MAX) ptr <= ptr + ADDR_W'(1);
          end
        end
        S_RUN: begin
          if (adv) begin
            cycles <= cyc_inc;
            if (core_instr == HALT_INSN) begin
              halted <= 1'b1;
              state  <= S_DONE;
            end else if (budget_q != '0 && cyc_inc == budget_q) begin
              timeout <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: imem writes are checked against a scoreboard queue.
module tb_core_run_ctrl;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nwr1 = 0;

  wr_t q0[$];
  wr_t q1[$];

  logic [31:0] prog7[7] = '{32'h012A4820, 32'h8D280004, 32'h11090002, 32'h0,
                            32'h0, 32'h012A4822, 32'hAD090000};
  logic [31:0] buf0[8];

  core_run_ctrl_if #(.DATA_W(32), .ADDR_W(6)) bus0 ();
  core_run_ctrl_if #(.DATA_W(32), .ADDR_W(3)) bus1 ();

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] budget0 = '0, budget1 = '0;
  logic [31:0] instr0 = '0, instr1 = '0;
  logic        core_rst_n0, ce0, busy0, done0, halted0, timeout0;
  logic        core_rst_n1, ce1, busy1, done1, halted1, timeout1;
  logic [15:0] cycles0, cycles1;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;

  core_run_ctrl #(.DATA_W(32), .ADDR_W(6), .CYCLE_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cycle_budget(budget0), .bus(bus0),
    .core_rst_n(core_rst_n0), .core_ce(ce0), .core_instr(instr0),
`ifdef CORE_RUN_CTRL_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .busy(busy0), .done(done0), .halted(halted0), .timeout(timeout0), .cycles(cycles0)
  );

  core_run_ctrl #(.DATA_W(32), .ADDR_W(3), .CYCLE_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cycle_budget(budget1), .bus(bus1),
    .core_rst_n(core_rst_n1), .core_ce(ce1), .core_instr(instr1),
`ifdef CORE_RUN_CTRL_SINGLE_STEP_EN
    .step_mode(1'b0), .step(1'b0),
`endif
    .busy(busy1), .done(done1), .halted(halted1), .timeout(timeout1), .cycles(cycles1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus0.imem_we === 1'b1) begin
      chk("u0_write_expected", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0_waddr", 32'(bus0.imem_waddr), 32'(e.a));
        chk("u0_wdata", bus0.imem_wdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus1.imem_we === 1'b1) begin
      nwr1++;
      chk("u1_write_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1_waddr", 32'(bus1.imem_waddr), 32'(e.a));
        chk("u1_wdata", bus1.imem_wdata, e.d);
      end
    end
  end

  task automatic load0(input logic [15:0] bud, input int n);
    wr_t e;
    @(posedge clk); #1;
    start0 = 1'b1;
    budget0 = bud;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("load_ready_in_load", bus0.load_ready, 1);
    for (int i = 0; i < n; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_data  = buf0[i];
      bus0.load_last  = (i == n - 1);
      e.a = 6'(i);
      e.d = buf0[i];
      q0.push_back(e);
      @(posedge clk); #1;
    end
    bus0.load_valid = 1'b0;
    bus0.load_last  = 1'b0;
    chk("load_ready_after_last", bus0.load_ready, 0);
    chk("core_rst_n_in_run", core_rst_n0, 1);
    chk("busy_in_run", busy0, 1);
  endtask

  task automatic wait_done0(input int limit, output int n);
    n = 0;
    while (!done0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int nce;
    bus0.load_valid = 1'b0; bus0.load_last = 1'b0; bus0.load_data = 32'hA5A5_0001;
    bus1.load_valid = 1'b0; bus1.load_last = 1'b0; bus1.load_data = 32'h0;

    // Reset values
    #2;
    chk("rst_load_ready", bus0.load_ready, 0);
    chk("rst_imem_we", bus0.imem_we, 0);
    chk("rst_imem_waddr", 32'(bus0.imem_waddr), 0);
    chk("rst_imem_wdata", bus0.imem_wdata, 32'hA5A5_0001);
    chk("rst_core_rst_n", core_rst_n0, 0);
    chk("rst_core_ce", ce0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_timeout", timeout0, 0);
    chk("rst_cycles", 32'(cycles0), 0);
    #10 rst_n = 1'b1;

    // Program load: 7 words at addresses 0..6
    for (int i = 0; i < 7; i++) buf0[i] = prog7[i];
    load0(16'd2, 7);
    chk("prog_core_ce", ce0, 1);
    wait_done0(20, n);
    chk("prog_done", done0, 1);
    chk("prog_cycles", 32'(cycles0), 2);

    // Halt on the 4th instruction
    for (int i = 0; i < 3; i++) buf0[i] = prog7[i];
    buf0[3] = HALT;
    load0(16'd0, 4);
    instr0 = buf0[0];
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("halt_running", core_rst_n0, 1);
      instr0 = buf0[i];
    end
    @(posedge clk); #1;
    instr0 = 32'h0;
    chk("halt_halted", halted0, 1);
    chk("halt_done", done0, 1);
    chk("halt_timeout", timeout0, 0);
    chk("halt_cycles", 32'(cycles0), 4);
    chk("halt_core_rst_n", core_rst_n0, 0);
    chk("halt_core_ce", ce0, 0);

    // Budget expiry
    buf0[0] = 32'h0;
    load0(16'd5, 1);
    wait_done0(20, n);
    chk("budget_latency", 32'(n), 5);
    chk("budget_done", done0, 1);
    chk("budget_timeout", timeout0, 1);
    chk("budget_halted", halted0, 0);
    chk("budget_cycles", 32'(cycles0), 5);

    // Halt lands on the same cycle as budget 3
    load0(16'd3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    instr0 = HALT;
    @(posedge clk); #1;
    instr0 = 32'h0;
    chk("coll_halted", halted0, 1);
    chk("coll_timeout", timeout0, 0);
    chk("coll_cycles", 32'(cycles0), 3);
    chk("coll_done", done0, 1);

    // Depth limit on the 8-entry instance
    @(posedge clk); #1;
    start1 = 1'b1;
    budget1 = 16'd2;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_t e;
      bus1.load_valid = 1'b1;
      bus1.load_data  = 32'h100 + 32'(i);
      chk("depth_ready", bus1.load_ready, 32'(i < 8));
      if (i < 8) begin
        e.a = 6'(i);
        e.d = bus1.load_data;
        q1.push_back(e);
      end
      @(posedge clk); #1;
    end
    bus1.load_valid = 1'b0;
    chk("depth_writes", 32'(nwr1), 8);
    chk("depth_queue_empty", 32'(q1.size()), 0);

`ifdef CORE_RUN_CTRL_SINGLE_STEP_EN
    // Single-step: three step pulses four cycles apart
    load0(16'd0, 1);
    step_mode = 1'b1;
    nce = 0;
    for (int c = 0; c < 12; c++) begin
      step = (c % 4 == 0);
      #1;
      if (ce0) nce++;
      @(posedge clk); #1;
    end
    step = 1'b0;
    chk("step_ce_count", 32'(nce), 3);
    chk("step_cycles", 32'(cycles0), 3);
    chk("step_core_rst_n", core_rst_n0, 1);
    step_mode = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
`else
    nce = 0;
`endif

    // Unlimited budget saturates, then async reset mid-run
    load0(16'd0, 1);
    repeat (65545) @(posedge clk);
    #1;
    chk("sat_cycles", 32'(cycles0), 32'hFFFF);
    chk("sat_busy", busy0, 1);
    chk("sat_done", done0, 0);
    chk("sat_timeout", timeout0, 0);
    bus0.load_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cycles", 32'(cycles0), 0);
    chk("arst_core_rst_n", core_rst_n0, 0);
    chk("arst_core_ce", ce0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_load_ready", bus0.load_ready, 0);
    chk("arst_imem_we", bus0.imem_we, 0);
    chk("arst_imem_waddr", 32'(bus0.imem_waddr), 0);
    bus0.load_valid = 1'b0;
    #2 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
